// File: rtl/sigmoid_host_seq.sv
// Host-side sequencer: loads 512 operands into one half of the operand BRAM,
// hands that half to the accelerator, then streams the 512 results back out.
module sigmoid_host_seq #(
  parameter int BRAM_WIDTH = 32,
  parameter int WORD_BYTES = 4,
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [31:0]           s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  output logic [31:0]           m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic [31:0]           ps_control,
  input  logic [31:0]           pl_status,
  output logic [ADDR_WIDTH-1:0] bram_addr_in,
  output logic [BRAM_WIDTH-1:0] bram_wrdata_in,
  output logic [WORD_BYTES-1:0] bram_we_in,
  output logic [ADDR_WIDTH-1:0] bram_addr_out,
  input  logic [BRAM_WIDTH-1:0] bram_rddata_out,
  output logic [WORD_BYTES-1:0] bram_we_out,
  output logic                  busy
);

  // state      | meaning                    state      | meaning
  // IDLE       | wait for first operand     RELEASE    | drop start request
  // FILL       | write 512 operands         WAIT_CLEAR | wait for status to clear
  // START      | raise start request        DRAIN      | stream 512 results out
  // WAIT_DONE  | wait for half's status bit
  typedef enum logic [2:0] {
    IDLE, FILL, START, WAIT_DONE, RELEASE, WAIT_CLEAR, DRAIN
  } state_t;

  localparam int HALF_B_BASE = 2048;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_half;
  logic [8:0]  r_count;
  logic [9:0]  r_rd_cnt;
  logic [9:0]  r_pop_cnt;
  logic        r_rd_inflight;
  logic [31:0] r_fifo [2];
  logic        r_fifo_wptr;
  logic        r_fifo_rptr;
  logic [1:0]  r_fifo_occ;
  logic [1:0]  r_ctrl;

  logic                  w_beat;
  logic                  w_last_beat;
  logic                  w_pop;
  logic                  w_last_pop;
  logic                  w_rd_issue;
  logic                  w_half_status;
  logic [1:0]            w_half_mask;
  logic [ADDR_WIDTH-1:0] w_base;
  logic                  w_unused_status;

  assign w_base        = r_half ? ADDR_WIDTH'(HALF_B_BASE) : '0;
  assign w_half_mask   = r_half ? 2'b10 : 2'b01;
  assign w_half_status = r_half ? pl_status[1] : pl_status[0];
  assign w_unused_status = ^pl_status[31:2];

  assign w_beat      = (r_state == FILL) && s_axis_tvalid;
  assign w_last_beat = w_beat && (r_count == 9'd511);
  assign w_pop       = m_axis_tvalid && m_axis_tready;
  assign w_last_pop  = w_pop && (r_pop_cnt == 10'd511);

  // Counting the pop of this cycle lets a read issue every cycle at full rate
  // while the FIFO can still never be overrun by the returning word.
  assign w_rd_issue = (r_state == DRAIN) && (r_rd_cnt < 10'd512) &&
                      ((r_fifo_occ + {1'b0, r_rd_inflight} - {1'b0, w_pop}) < 2'd2);

  assign s_axis_tready  = (r_state == FILL);
  assign bram_we_in     = w_beat ? '1 : '0;
  assign bram_wrdata_in = BRAM_WIDTH'(s_axis_tdata);
  assign bram_addr_in   = w_base + ADDR_WIDTH'({r_count, 2'b00});
  assign bram_addr_out  = w_base + ADDR_WIDTH'({r_rd_cnt[8:0], 2'b00});
  assign bram_we_out    = '0;
  assign m_axis_tvalid  = (r_fifo_occ != 2'd0);
  assign m_axis_tdata   = r_fifo[r_fifo_rptr];
  assign ps_control     = {30'd0, r_ctrl};
  assign busy           = (r_state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:       if (s_axis_tvalid) w_state_nxt = FILL;
      FILL:       if (w_last_beat) w_state_nxt = START;
      START:      w_state_nxt = WAIT_DONE;
      WAIT_DONE:  if (w_half_status) w_state_nxt = RELEASE;
      RELEASE:    w_state_nxt = WAIT_CLEAR;
      WAIT_CLEAR: if (!w_half_status) w_state_nxt = DRAIN;
      DRAIN:      if (w_last_pop) w_state_nxt = IDLE;
      default:    w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_half        <= 1'b0;
      r_count       <= '0;
      r_rd_cnt      <= '0;
      r_pop_cnt     <= '0;
      r_rd_inflight <= 1'b0;
      r_fifo_wptr   <= 1'b0;
      r_fifo_rptr   <= 1'b0;
      r_fifo_occ    <= '0;
      r_ctrl        <= '0;
    end else begin
      if ((r_state == IDLE) && s_axis_tvalid)
        r_count <= '0;
      else if (w_beat)
        r_count <= w_last_beat ? 9'd0 : r_count + 9'd1;

      if (r_state == START)   r_ctrl <= r_ctrl | w_half_mask;
      if (r_state == RELEASE) r_ctrl <= r_ctrl & ~w_half_mask;

      if ((r_state == WAIT_CLEAR) && !w_half_status) begin
        r_rd_cnt  <= '0;
        r_pop_cnt <= '0;
      end else begin
        if (w_rd_issue) r_rd_cnt  <= r_rd_cnt + 10'd1;
        if (w_pop)      r_pop_cnt <= r_pop_cnt + 10'd1;
      end

      r_rd_inflight <= w_rd_issue;
      if (r_rd_inflight) r_fifo_wptr <= ~r_fifo_wptr;
      if (w_pop)         r_fifo_rptr <= ~r_fifo_rptr;
      r_fifo_occ <= r_fifo_occ + {1'b0, r_rd_inflight} - {1'b0, w_pop};

      if (w_last_pop) r_half <= ~r_half;
    end
  end

  always_ff @(posedge clk) begin
    if (r_rd_inflight) r_fifo[r_fifo_wptr] <= 32'(bram_rddata_out);
  end

endmodule

// File: tb/tb_sigmoid_host_seq.sv
// Scoreboard bench for sigmoid_host_seq with BRAM and accelerator models.
module tb_sigmoid_host_seq;
  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] s_axis_tdata;
  logic        s_axis_tvalid;
  logic        s_axis_tready;
  logic [31:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic [31:0] ps_control;
  logic [31:0] pl_status;
  logic [11:0] bram_addr_in;
  logic [31:0] bram_wrdata_in;
  logic [3:0]  bram_we_in;
  logic [11:0] bram_addr_out;
  logic [31:0] bram_rddata_out;
  logic [3:0]  bram_we_out;
  logic        busy;

  always #5 clk = ~clk;

  sigmoid_host_seq dut (
    .clk(clk), .reset(reset),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .ps_control(ps_control), .pl_status(pl_status),
    .bram_addr_in(bram_addr_in), .bram_wrdata_in(bram_wrdata_in), .bram_we_in(bram_we_in),
    .bram_addr_out(bram_addr_out), .bram_rddata_out(bram_rddata_out), .bram_we_out(bram_we_out),
    .busy(busy)
  );

  int total = 0;
  int bad = 0;
  logic [31:0] exp_q[$];
  logic [31:0] op_mem  [0:1023];
  logic [31:0] res_mem [0:1023];
  int exp_base = 0;
  int wr_seen = 0;
  int pops = 0;
  bit tog = 1'b0;
  bit half_b = 1'b0;
  bit stalled = 1'b0;
  logic [31:0] stall_data = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  task automatic fail_timeout(input string name);
    total++;
    bad++;
    $display("FAIL %s: got timeout want event", name);
  endtask

  // Exact IEEE-754 single encoding of a positive integer below 2^24.
  function automatic logic [31:0] int2f(input int n);
    int e = 0;
    logic [31:0] m;
    for (int b = 0; b < 24; b++) if (n >= (1 << b)) e = b;
    m = (32'(n) << (23 - e)) & 32'h007F_FFFF;
    return {1'b0, 8'(127 + e), m[22:0]};
  endfunction

  always @(posedge clk) begin
    if (bram_we_in != 4'h0) op_mem[bram_addr_in[11:2]] <= bram_wrdata_in;
    bram_rddata_out <= res_mem[bram_addr_out[11:2]];
  end

  always @(posedge clk) begin
    #1;
    m_axis_tready = tog ? ~m_axis_tready : 1'b1;
  end

  always @(negedge clk) begin
    if (bram_we_in != 4'h0) begin
      check("wr_addr", 32'(bram_addr_in), 32'(exp_base + 4 * wr_seen));
      check("wr_data", bram_wrdata_in, s_axis_tdata);
      check("wr_be", 32'(bram_we_in), 32'h0000_000F);
      wr_seen++;
    end
  end

  always @(negedge clk) begin
    if (stalled) begin
      check("stall_valid", 32'(m_axis_tvalid), 32'd1);
      check("stall_data", m_axis_tdata, stall_data);
    end
    if (m_axis_tvalid && m_axis_tready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL result_extra: got %h want none", m_axis_tdata);
      end else begin
        check("result", m_axis_tdata, exp_q.pop_front());
      end
      pops++;
    end
    stalled = m_axis_tvalid && !m_axis_tready && !reset;
    stall_data = m_axis_tdata;
  end

  task automatic run_batch(input int off, input logic [31:0] salt,
                           input bit gaps, input bit tgl, input bit abort);
    logic [31:0] own;
    logic [31:0] oth;
    logic [31:0] w;
    bit ok;
    bit seen;
    int t0;
    int tend;
    own = half_b ? 32'h2 : 32'h1;
    oth = half_b ? 32'h1 : 32'h2;
    exp_base = half_b ? 2048 : 0;
    wr_seen = 0;
    pops = 0;
    tog = tgl;
    for (int i = 0; i < 512; i++) begin
      if (gaps && (i % 3 == 2)) begin
        s_axis_tvalid = 1'b0;
        @(posedge clk); #1;
      end
      if (i == 511) check("no_early_start", ps_control, 32'h0);
      w = int2f(i + off) ^ salt;
      s_axis_tvalid = 1'b1;
      s_axis_tdata = w;
      if (!abort) exp_q.push_back(~w);
      ok = 1'b0;
      for (int t = 0; t < 8 && !ok; t++) begin
        @(negedge clk);
        ok = s_axis_tready;
        @(posedge clk); #1;
      end
      if (!ok) begin
        s_axis_tvalid = 1'b0;
        fail_timeout("fill_accept");
        return;
      end
    end
    s_axis_tvalid = 1'b0;
    check("wr_count", 32'(wr_seen), 32'd512);

    ok = 1'b0;
    for (int t = 0; t < 10 && !ok; t++) begin
      @(posedge clk); #2;
      ok = (ps_control != 32'h0);
    end
    check("ps_start", ps_control, own);

    if (abort) begin
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      check("abort_ps", ps_control, 32'h0);
      check("abort_busy", 32'(busy), 32'd0);
      pl_status = '0;
      half_b = 1'b0;
      return;
    end

    for (int t = 1; t <= 10; t++) begin
      @(posedge clk); #1;
      if (t == 2) pl_status = pl_status | oth;
      if (t == 8) begin
        check("other_bit_ignored", ps_control, own);
        check("other_bit_busy", 32'(busy), 32'd1);
        pl_status = pl_status & ~oth;
      end
    end
    for (int j = 0; j < 512; j++) res_mem[exp_base / 4 + j] = ~op_mem[exp_base / 4 + j];
    pl_status = pl_status | own;

    ok = 1'b0;
    for (int t = 0; t < 10 && !ok; t++) begin
      @(posedge clk); #2;
      ok = (ps_control == 32'h0);
    end
    if (!ok) fail_timeout("ps_release");
    @(posedge clk); #1;
    @(posedge clk); #1;
    pl_status = pl_status & ~own;

    seen = 1'b0;
    t0 = 0;
    tend = -1;
    for (int t = 0; t < 3000 && tend < 0; t++) begin
      @(posedge clk); #2;
      if (!seen && m_axis_tvalid) begin
        seen = 1'b1;
        t0 = t;
      end
      if (pops >= 512) tend = t;
    end
    if (tend < 0) begin
      fail_timeout("drain_done");
    end else begin
      if (!tgl) check("throughput", 32'(tend - t0), 32'd512);
      check("busy_end", 32'(busy), 32'd0);
      check("queue_empty", 32'(exp_q.size()), 32'd0);
    end
    half_b = ~half_b;
  endtask

  initial begin
    reset = 1'b1;
    s_axis_tvalid = 1'b1;
    s_axis_tdata = 32'h3F80_0000;
    pl_status = '0;
    m_axis_tready = 1'b1;
    for (int j = 0; j < 1024; j++) res_mem[j] = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ps", ps_control, 32'h0);
    check("rst_tready", 32'(s_axis_tready), 32'd0);
    check("rst_mvalid", 32'(m_axis_tvalid), 32'd0);
    check("rst_we_in", 32'(bram_we_in), 32'd0);
    check("rst_we_out", 32'(bram_we_out), 32'd0);
    check("rst_addr_in", 32'(bram_addr_in), 32'd0);
    s_axis_tvalid = 1'b0;
    reset = 1'b0;
    @(posedge clk); #1;

    run_batch(1,   32'h0000_0000, 1'b0, 1'b0, 1'b0);
    run_batch(1,   32'h8000_0000, 1'b0, 1'b0, 1'b0);
    run_batch(513, 32'h0000_0000, 1'b1, 1'b1, 1'b0);
    run_batch(1,   32'h8000_0000, 1'b0, 1'b0, 1'b1);
    run_batch(100, 32'h0000_0000, 1'b0, 1'b0, 1'b0);

    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no end want finish");
    $fatal(1, "watchdog expired");
  end

endmodule
